e203_ifu_ir_buf: RTL and testbench



---
 rtl/e203_ifu_ir_buf_pkg.sv | 11 +
 rtl/e203_ifu_ir_entry.sv | 29 ++
 rtl/e203_ifu_ir_buf.sv | 88 ++++++++
 tb/tb_e203_ifu_ir_buf.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/e203_ifu_ir_buf_pkg.sv
// e203_ifu_ir_buf_pkg: shared widths, payload width helper and occupancy states for the IR buffer
package e203_ifu_ir_buf_pkg;
  localparam int E203_PC_SIZE = 32;
  localparam int E203_INSTR_SIZE = 32;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_IR_PLD_W = E203_INSTR_SIZE + E203_PC_SIZE + 3;
  typedef enum logic [1:0] {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_TWO = 2'd2} occ_e;
  function automatic int ir_pld_w(input int instr_size, input int pc_size);
    return instr_size + pc_size + 3;
  endfunction
endpackage

// File: rtl/e203_ifu_ir_entry.sv
// e203_ifu_ir_entry: load-enabled IR payload register with masked rs1/rs2 index extraction
module e203_ifu_ir_entry
  import e203_ifu_ir_buf_pkg::*;
#(
  parameter int INSTR_SIZE = E203_INSTR_SIZE,
  parameter int PC_SIZE = E203_PC_SIZE
) (
  input  logic                                         clk,
  input  logic                                         ld,
  input  logic [ir_pld_w(INSTR_SIZE, PC_SIZE)-1:0]     d_pld,
  output logic [ir_pld_w(INSTR_SIZE, PC_SIZE)-1:0]     q_pld,
  output logic [E203_RFIDX_WIDTH-1:0]                  rs1idx,
  output logic [E203_RFIDX_WIDTH-1:0]                  rs2idx
);
  localparam int W = ir_pld_w(INSTR_SIZE, PC_SIZE);
  localparam int IB = PC_SIZE + 3;
  logic [W-1:0] pld_q, pld_d;
  logic err;
  // hold the payload unless a new entry is loaded; payload is deliberately not reset
  always_comb pld_d = ld ? d_pld : pld_q;
  always_ff @(posedge clk) pld_q <= pld_d;
  // faulted fetches carry no real instruction, so their regfile indices read x0
  always_comb begin
    err = pld_q[1] | pld_q[0];
    q_pld = pld_q;
    rs1idx = err ? '0 : pld_q[IB+15 +: E203_RFIDX_WIDTH];
    rs2idx = err ? '0 : pld_q[IB+20 +: E203_RFIDX_WIDTH];
  end
endmodule

// File: rtl/e203_ifu_ir_buf.sv
// e203_ifu_ir_buf: IFU-to-decode IR buffer; E203_IFU_IR_SKID_EN selects a 2-entry skid buffer, else a 1-entry pipe register
module e203_ifu_ir_buf
  import e203_ifu_ir_buf_pkg::*;
#(
  parameter int PC_SIZE = E203_PC_SIZE,
  parameter int INSTR_SIZE = E203_INSTR_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [INSTR_SIZE-1:0]       i_instr,
  input  logic [PC_SIZE-1:0]          i_pc,
  input  logic                        i_prdt_taken,
  input  logic                        i_misalgn,
  input  logic                        i_buserr,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [INSTR_SIZE-1:0]       o_instr,
  output logic [PC_SIZE-1:0]          o_pc,
  output logic                        o_prdt_taken,
  output logic                        o_misalgn,
  output logic                        o_buserr,
  output logic [E203_RFIDX_WIDTH-1:0] o_rs1idx,
  output logic [E203_RFIDX_WIDTH-1:0] o_rs2idx,
  output logic [1:0]                  o_occ
);
  localparam int W = ir_pld_w(INSTR_SIZE, PC_SIZE);
  occ_e occ_q, occ_d;
  logic push, pop;
  logic [W-1:0] in_pld, hd_pld;
  // handshake, occupancy next-state and head payload unpacking
  always_comb begin
`ifdef E203_IFU_IR_SKID_EN
    i_ready = occ_q != OCC_TWO;
`else
    i_ready = (occ_q == OCC_EMPTY) | o_ready;
`endif
    in_pld = {i_instr, i_pc, i_prdt_taken, i_misalgn, i_buserr};
    o_valid = (occ_q != OCC_EMPTY) & ~flush;
    push = i_valid & i_ready & ~flush;
    pop = o_valid & o_ready;
    occ_d = flush ? OCC_EMPTY : occ_e'(2'(occ_q) + {1'b0, push} - {1'b0, pop});
    {o_instr, o_pc, o_prdt_taken, o_misalgn, o_buserr} = hd_pld;
    o_occ = occ_q;
  end
`ifdef E203_IFU_IR_SKID_EN
  logic rd_q, rd_d, wr_q, wr_d;
  logic [W-1:0] pld0, pld1;
  logic [E203_RFIDX_WIDTH-1:0] rs1_0, rs2_0, rs1_1, rs2_1;
  // two-slot ring: write pointer follows pushes, read pointer follows pops and selects the head
  always_comb begin
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    wr_d = flush ? 1'b0 : wr_q ^ push;
    hd_pld = rd_q ? pld1 : pld0;
    o_rs1idx = rd_q ? rs1_1 : rs1_0;
    o_rs2idx = rd_q ? rs2_1 : rs2_0;
  end
  // occupancy and ring pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= OCC_EMPTY;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  e203_ifu_ir_entry #(.INSTR_SIZE(INSTR_SIZE), .PC_SIZE(PC_SIZE)) u_ent0 (
    .clk(clk), .ld(push & ~wr_q), .d_pld(in_pld), .q_pld(pld0), .rs1idx(rs1_0), .rs2idx(rs2_0)
  );
  e203_ifu_ir_entry #(.INSTR_SIZE(INSTR_SIZE), .PC_SIZE(PC_SIZE)) u_ent1 (
    .clk(clk), .ld(push & wr_q), .d_pld(in_pld), .q_pld(pld1), .rs1idx(rs1_1), .rs2idx(rs2_1)
  );
`else
  // occupancy of the single pipe register
  always_ff @(posedge clk) begin
    if (rst) occ_q <= OCC_EMPTY;
    else occ_q <= occ_d;
  end
  e203_ifu_ir_entry #(.INSTR_SIZE(INSTR_SIZE), .PC_SIZE(PC_SIZE)) u_ent0 (
    .clk(clk), .ld(push), .d_pld(in_pld), .q_pld(hd_pld), .rs1idx(o_rs1idx), .rs2idx(o_rs2idx)
  );
`endif
endmodule

// File: tb/tb_e203_ifu_ir_buf.sv
// tb_e203_ifu_ir_buf: directed self-checking bench for e203_ifu_ir_buf (either E203_IFU_IR_SKID_EN build)
module tb_e203_ifu_ir_buf;
`ifdef E203_IFU_IR_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0, rst, flush, i_valid, i_ready, i_prdt_taken, i_misalgn, i_buserr;
  logic o_valid, o_ready, o_prdt_taken, o_misalgn, o_buserr;
  logic [31:0] i_instr, i_pc, o_instr, o_pc;
  logic [4:0] o_rs1idx, o_rs2idx;
  logic [1:0] o_occ;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  e203_ifu_ir_buf dut (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_ready(i_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_prdt_taken(i_prdt_taken), .i_misalgn(i_misalgn),
    .i_buserr(i_buserr), .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_prdt_taken(o_prdt_taken), .o_misalgn(o_misalgn), .o_buserr(o_buserr),
    .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx), .o_occ(o_occ)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic me, input logic be);
    i_valid = v;
    i_instr = instr;
    i_pc = pc;
    i_misalgn = me;
    i_buserr = be;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; flush = 1'b0; o_ready = 1'b0; i_prdt_taken = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_occ", o_occ, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_iready", i_ready, 1);
    // stream 4 entries with o_ready high
    o_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h00000013 + (k << 7), 32'h80000000 + 32'(4 * k), 1'b0, 1'b0);
      @(negedge clk);
      chk("stream_iready", i_ready, 1);
      chk("stream_valid", o_valid, k > 0);
      if (k > 0) begin
        chk("stream_pc", o_pc, 32'h80000000 + 32'(4 * (k - 1)));
        chk("stream_occ", o_occ, 1);
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_last_pc", o_pc, 32'h8000000C);
    chk("stream_last_valid", o_valid, 1);
    tick();
    @(negedge clk);
    chk("stream_drain_valid", o_valid, 0);
    chk("stream_drain_occ", o_occ, 0);
    // two pushes with decode stalled
    tick();
    o_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 32'h100, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_a_iready", i_ready, 1);
    tick();
    drive(1'b1, 32'h00B00113, 32'h104, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_b_iready", i_ready, SKID);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_occ", o_occ, SKID ? 2 : 1);
    chk("full_iready", i_ready, 0);
    chk("head_a_instr", o_instr, 32'h00A00093);
    chk("head_a_pc", o_pc, 32'h100);
    chk("head_a_rs1", o_rs1idx, 0);
    chk("head_a_rs2", o_rs2idx, 10);
    o_ready = 1'b1;
    #1;
    chk("pop_a_iready_same_cycle", i_ready, !SKID);
    tick();
    @(negedge clk);
    chk("after_pop_a_occ", o_occ, SKID ? 1 : 0);
    chk("after_pop_a_valid", o_valid, SKID);
    chk("after_pop_a_iready", i_ready, 1);
`ifdef E203_IFU_IR_SKID_EN
    chk("head_b_instr", o_instr, 32'h00B00113);
    chk("head_b_pc", o_pc, 32'h104);
    chk("head_b_rs2", o_rs2idx, 11);
`endif
    tick();
    @(negedge clk);
    chk("drain_b_occ", o_occ, 0);
    // fault masking of rs indices
    tick();
    o_ready = 1'b0;
    drive(1'b1, 32'hFFFFFFFF, 32'h200, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("buserr_flag", o_buserr, 1);
    chk("buserr_instr", o_instr, 32'hFFFFFFFF);
    chk("buserr_rs1", o_rs1idx, 0);
    chk("buserr_rs2", o_rs2idx, 0);
    tick();
    o_ready = 1'b1;
    drive(1'b1, 32'hFFFFFFFF, 32'h204, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk("clean_pc", o_pc, 32'h204);
    chk("clean_occ", o_occ, 1);
    chk("clean_buserr", o_buserr, 0);
    chk("clean_rs1", o_rs1idx, 31);
    chk("clean_rs2", o_rs2idx, 31);
    tick();
    drive(1'b1, 32'hFFFFFFFF, 32'h208, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("misalgn_flag", o_misalgn, 1);
    chk("misalgn_rs1", o_rs1idx, 0);
    chk("misalgn_rs2", o_rs2idx, 0);
    tick();
    @(negedge clk);
    chk("fault_drain_occ", o_occ, 0);
    // flush with a push and a ready decoder
    tick();
    o_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00000013, 32'h304, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    o_ready = 1'b1;
    drive(1'b1, 32'h00000013, 32'h308, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_occ_before", o_occ, SKID ? 2 : 1);
    chk("flush_valid", o_valid, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_flush_occ", o_occ, 0);
    chk("post_flush_valid", o_valid, 0);
    chk("post_flush_iready", i_ready, 1);
    drive(1'b1, 32'h00000013, 32'h30C, 1'b0, 1'b0);
    o_ready = 1'b0;
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_flush_push_valid", o_valid, 1);
    chk("post_flush_push_pc", o_pc, 32'h30C);
    chk("post_flush_push_occ", o_occ, 1);
    // reset mid-stream with one entry held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_occ", o_occ, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_iready", i_ready, 1);
    drive(1'b1, 32'h00000013, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_push_valid", o_valid, 1);
    chk("midrst_push_pc", o_pc, 32'h400);
    // o_ready toggle with a held head, then push+pop replaces the head
    drive(1'b1, 32'h00000013, 32'h500, 1'b0, 1'b0);
    #1;
    chk("toggle_iready_low", i_ready, SKID);
    o_ready = 1'b1;
    #1;
    chk("toggle_iready_high", i_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    o_ready = 1'b0;
    @(negedge clk);
    chk("replace_pc", o_pc, 32'h500);
    chk("replace_occ", o_occ, 1);
    chk("replace_valid", o_valid, 1);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
